// File: rtl/wac_spi_scheduler.sv
// ---------------------------------------------------------------------------
// wac_spi_scheduler
//
// Shared serial-bus scheduler for the WAC reference chain. Four requesters
// (source 0 = DAC, sources 1..3 = digital pots 1..3) share one SCLK/SDI
// pair. Requests are granted round-robin and the granted word is sent
// MSB-first. The block drives the DAC sync and the three pot chip selects.
//
// Parameters
//   CLK_DIV   clk cycles per SCLK half-period (1..255)
//   DAC_BITS  frame length for source 0 (<=16)
//   POT_BITS  frame length for sources 1..3 (<=16, low bits of the word)
//   GAP_CYC   clk cycles all selects stay high after a frame (>=1)
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous reset, active high
//   req       in   [3:0] level request per source
//   reqData   in   [63:0] word per source, [16*i+15:16*i] for source i
//   grant     out  [3:0] one-hot, high for the whole frame of the served source
//   done      out  one-cycle pulse at frame end
//   busy      out  high from grant to the end of the inter-frame gap
//   sclkDac   out  shared serial clock, idle low
//   sdiDac    out  shared serial data
//   syncDac   out  DAC frame select, active low
//   csPot     out  [2:0] pot selects, active low, [k] = pot k+1
//   frameCnt  out  [15:0] completed-frame counter (only with the macro below)
//
// Build option
//   WAC_SPI_FRAME_CNT_EN : adds the frameCnt output, counting every done
//                          pulse and wrapping 0xFFFF -> 0x0000.
// ---------------------------------------------------------------------------
module wac_spi_scheduler #(
  parameter int CLK_DIV  = 4,
  parameter int DAC_BITS = 16,
  parameter int POT_BITS = 8,
  parameter int GAP_CYC  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [63:0] reqData,
  output logic [3:0]  grant,
  output logic        done,
  output logic        busy,
  output logic        sclkDac,
  output logic        sdiDac,
  output logic        syncDac,
  output logic [2:0]  csPot
`ifdef WAC_SPI_FRAME_CNT_EN
  ,
  output logic [15:0] frameCnt
`endif
);

  // Timing constants. The phase counter walks 0..2N: phase 0 is the
  // select-to-first-edge setup, odd phases are SCLK high, even phases
  // after 0 are SCLK low, and the final low phase is the hold time.
  localparam logic [7:0]  DIV_LAST    = 8'(CLK_DIV - 1);
  localparam logic [5:0]  DAC_LAST_PH = 6'(2 * DAC_BITS);
  localparam logic [5:0]  POT_LAST_PH = 6'(2 * POT_BITS);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYC - 1);
  localparam int          DAC_ALIGN   = 16 - DAC_BITS;
  localparam int          POT_ALIGN   = 16 - POT_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t      state_reg;
  logic [3:0]  grant_reg;
  logic        done_reg;
  logic        busy_reg;
  logic        sclk_reg;
  logic        sdi_reg;
  logic [3:0]  sel_n_reg;       // [0] = DAC sync, [3:1] = pot selects
  logic [1:0]  rr_ptr_reg;
  logic [1:0]  served_reg;
  logic [14:0] shift_reg;       // bits still to send, next one at [14]
  logic [7:0]  div_cnt_reg;
  logic [5:0]  phase_reg;
  logic [5:0]  last_phase_reg;
  logic [15:0] gap_cnt_reg;
`ifdef WAC_SPI_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;
`endif

  // Per-source word view of the packed request data.
  logic [15:0] src_word [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign src_word[gi] = reqData[16*gi +: 16];
    end
  endgenerate

  // Round-robin pick: scan downward from the farthest candidate so the
  // last hit is the one nearest to rr_ptr_reg (scanning upward, wrapping).
  logic [1:0] pick_idx;
  logic       pick_valid;
  logic [1:0] scan_idx;

  always_comb begin
    pick_idx   = 2'd0;
    pick_valid = 1'b0;
    scan_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = rr_ptr_reg + 2'(k);
      if (req[scan_idx]) begin
        pick_idx   = scan_idx;
        pick_valid = 1'b1;
      end
    end
  end

  // Word of the picked source, left-aligned so its MSB sits in bit 15.
  // Pot frames carry the low POT_BITS of the word.
  logic [15:0] pick_word;
  logic [5:0]  pick_last_ph;
  logic [3:0]  pick_onehot;

  always_comb begin
    pick_word    = 16'd0;
    pick_last_ph = POT_LAST_PH;
    if (pick_idx == 2'd0) begin
      pick_word    = src_word[0] << DAC_ALIGN;
      pick_last_ph = DAC_LAST_PH;
    end else begin
      pick_word    = src_word[pick_idx] << POT_ALIGN;
    end
    pick_onehot = 4'b0001 << pick_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= 4'b0000;
      done_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      sclk_reg       <= 1'b0;
      sdi_reg        <= 1'b0;
      sel_n_reg      <= 4'b1111;
      rr_ptr_reg     <= 2'd0;
      served_reg     <= 2'd0;
      shift_reg      <= 15'd0;
      div_cnt_reg    <= 8'd0;
      phase_reg      <= 6'd0;
      last_phase_reg <= 6'd0;
      gap_cnt_reg    <= 16'd0;
`ifdef WAC_SPI_FRAME_CNT_EN
      frame_cnt_reg  <= 16'd0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            // Latch the word now; later reqData changes cannot disturb
            // the frame. MSB is on sdi together with the falling select.
            grant_reg      <= pick_onehot;
            sel_n_reg      <= ~pick_onehot;
            busy_reg       <= 1'b1;
            sdi_reg        <= pick_word[15];
            shift_reg      <= pick_word[14:0];
            served_reg     <= pick_idx;
            last_phase_reg <= pick_last_ph;
            div_cnt_reg    <= 8'd0;
            phase_reg      <= 6'd0;
            sclk_reg       <= 1'b0;
            state_reg      <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= 8'd0;
            if (phase_reg == last_phase_reg) begin
              // Hold phase finished: release select, drop grant and
              // pulse done in the same cycle.
              sel_n_reg   <= 4'b1111;
              grant_reg   <= 4'b0000;
              done_reg    <= 1'b1;
              sclk_reg    <= 1'b0;
              sdi_reg     <= 1'b0;
              rr_ptr_reg  <= served_reg + 2'd1;
              gap_cnt_reg <= 16'd0;
              state_reg   <= ST_GAP;
`ifdef WAC_SPI_FRAME_CNT_EN
              frame_cnt_reg <= frame_cnt_reg + 16'd1;
`endif
            end else begin
              phase_reg <= phase_reg + 6'd1;
              if (!phase_reg[0]) begin
                // Low (or setup) phase ends: rising edge, slave samples.
                sclk_reg <= 1'b1;
              end else begin
                // High phase ends: falling edge, advance data unless the
                // coming low phase is the final hold phase.
                sclk_reg <= 1'b0;
                if (phase_reg + 6'd1 != last_phase_reg) begin
                  sdi_reg   <= shift_reg[14];
                  shift_reg <= {shift_reg[13:0], 1'b0};
                end
              end
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 8'd1;
          end
        end

        ST_GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 16'd1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant   = grant_reg;
  assign done    = done_reg;
  assign busy    = busy_reg;
  assign sclkDac = sclk_reg;
  assign sdiDac  = sdi_reg;
  assign syncDac = sel_n_reg[0];
  assign csPot   = sel_n_reg[3:1];
`ifdef WAC_SPI_FRAME_CNT_EN
  assign frameCnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_wac_spi_scheduler.sv
// ---------------------------------------------------------------------------
// tb_wac_spi_scheduler
//
// Scoreboard bench. Stimulus tasks compute the expected frame sequence from
// the round-robin rule (served order, frame length, word bits) and push it
// into exp_q; an independent pin monitor rebuilds each frame from the select,
// sclk and sdi pins, pops the next expectation at the end of the frame and
// compares. The monitor also checks the pin-level invariants every cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wac_spi_scheduler;

  localparam int CLK_DIV  = 2;
  localparam int DAC_BITS = 16;
  localparam int POT_BITS = 8;
  localparam int GAP_CYC  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [63:0] reqData = 64'd0;
  logic [3:0]  grant;
  logic        done;
  logic        busy;
  logic        sclkDac;
  logic        sdiDac;
  logic        syncDac;
  logic [2:0]  csPot;
`ifdef WAC_SPI_FRAME_CNT_EN
  logic [15:0] frameCnt;
`endif

  always #5 clk = ~clk;

  wac_spi_scheduler #(
    .CLK_DIV (CLK_DIV),
    .DAC_BITS(DAC_BITS),
    .POT_BITS(POT_BITS),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .reqData (reqData),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .sclkDac (sclkDac),
    .sdiDac  (sdiDac),
    .syncDac (syncDac),
    .csPot   (csPot)
`ifdef WAC_SPI_FRAME_CNT_EN
    ,
    .frameCnt(frameCnt)
`endif
  );

  typedef struct {
    int          src;
    logic [15:0] word;
    int          nbits;
  } frame_t;

  frame_t exp_q[$];
  int     total = 0;
  int     bad = 0;
  int     rr_m = 0;
  int     fc_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbits_of(input int s);
    return (s == 0) ? DAC_BITS : POT_BITS;
  endfunction

  function automatic logic [15:0] low_bits(input logic [15:0] w, input int n);
    logic [15:0] m;
    m = (n >= 16) ? 16'hFFFF : ((16'd1 << n) - 16'd1);
    return w & m;
  endfunction

  // First requesting source at or after rr, wrapping.
  function automatic int pick_next(input int rr, input logic [3:0] mask);
    for (int k = 0; k < 4; k++) begin
      if (mask[(rr + k) % 4]) return (rr + k) % 4;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      if (v[k]) return k;
    end
    return 0;
  endfunction

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    logic [3:0]  sel_low;
    logic        prev_sclk;
    bit          in_frame;
    int          cur;
    int          low_cnt;
    int          rise;
    int          gap;
    logic [15:0] bits;
    frame_t      e;
    prev_sclk = 1'b0;
    in_frame  = 1'b0;
    cur = 0; low_cnt = 0; rise = 0; gap = 1000; bits = 16'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame  = 1'b0;
        gap       = 1000;
        prev_sclk = 1'b0;
        fc_m      = 0;
        continue;
      end
      sel_low = ~{csPot, syncDac};
      chk("one_select", 32'($countones(sel_low) <= 1), 1);
      if (sel_low != 4'b0000) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          cur      = idx_of(sel_low);
          low_cnt  = 0;
          rise     = 0;
          bits     = 16'd0;
          chk("gap_len", 32'(gap >= GAP_CYC + 1), 1);
        end
        chk("select_src", sel_low, 4'b0001 << cur);
        chk("grant_frame", grant, 4'b0001 << cur);
        chk("busy_frame", busy, 1);
        chk("done_mid", done, 0);
        low_cnt++;
        if (sclkDac && !prev_sclk) begin
          rise++;
          bits = {bits[14:0], sdiDac};
        end
      end else begin
        chk("idle_sclk", sclkDac, 0);
        chk("idle_sdi", sdiDac, 0);
        chk("idle_grant", grant, 0);
        if (in_frame) begin
          chk("done_at_end", done, 1);
          chk("busy_at_end", busy, 1);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("frame_src", cur, e.src);
            chk("select_cycles", low_cnt, CLK_DIV * (2 * e.nbits + 1));
            chk("sclk_rises", rise, e.nbits);
            chk("frame_bits", bits, e.word);
            $display("frame src=%0d nbits=%0d sent=%h expected=%h low_cycles=%0d",
                     cur, rise, bits, e.word, low_cnt);
          end
          fc_m = (fc_m + 1) & 16'hFFFF;
`ifdef WAC_SPI_FRAME_CNT_EN
          chk("frame_cnt", frameCnt, fc_m);
`endif
          in_frame = 1'b0;
          gap      = 1;
        end else begin
          chk("stray_done", done, 0);
          gap++;
        end
      end
      prev_sclk = sclkDac;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (busy && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  // Every source in mask requests once and holds until its own done.
  task automatic serve(input logic [3:0] mask, input bit mangle,
                       input bit fixed_en, input logic [15:0] fixed_word);
    logic [3:0]  pend;
    logic [3:0]  tmp;
    logic [15:0] w [4];
    int          s;
    int          cur;
    int          cyc;
    int          fcyc;
    int          mangle_at;
    bit          mangled;
    for (int i = 0; i < 4; i++) begin
      w[i] = fixed_en ? fixed_word : 16'($urandom);
      reqData[16*i +: 16] = w[i];
    end
    tmp = mask;
    while (tmp != 4'b0000) begin
      s = pick_next(rr_m, tmp);
      exp_q.push_back('{src: s, word: low_bits(w[s], nbits_of(s)), nbits: nbits_of(s)});
      rr_m = (s + 1) % 4;
      tmp[s] = 1'b0;
    end
    req  = mask;
    pend = mask;
    cur = 0; fcyc = 0; mangled = 1'b0;
    mangle_at = $urandom_range(2, 30);
    @(posedge clk); #1;
    chk("latency", 32'({csPot, syncDac} != 4'b1111), 1);
    cyc = 0;
    while (pend != 4'b0000 && cyc < 2000) begin
      if (grant != 4'b0000) begin
        cur = idx_of(grant);
        fcyc++;
        if (mangle && !mangled && fcyc == mangle_at) begin
          // Latched word must survive both a data change and a dropped req.
          reqData[16*cur +: 16] = ~reqData[16*cur +: 16];
          req[cur] = 1'b0;
          mangled  = 1'b1;
        end
      end
      if (done) begin
        req[cur]  = 1'b0;
        pend[cur] = 1'b0;
        fcyc      = 0;
        mangled   = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("batch_timeout", pend, 0);
    wait_idle();
  endtask

  // Requests in mask stay high across n frames, re-competing after each done.
  task automatic serve_held(input logic [3:0] mask, input int n);
    int s;
    int dones;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      reqData[16*i +: 16] = 16'($urandom);
    end
    for (int k = 0; k < n; k++) begin
      s = pick_next(rr_m, mask);
      exp_q.push_back('{src: s, word: low_bits(reqData[16*s +: 16], nbits_of(s)),
                        nbits: nbits_of(s)});
      rr_m = (s + 1) % 4;
    end
    req = mask;
    dones = 0;
    cyc = 0;
    while (dones < n && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        dones++;
        if (dones == n) req = 4'b0000;
      end
    end
    chk("held_timeout", dones, n);
    req = 4'b0000;
    wait_idle();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_syncDac"}, syncDac, 1);
    chk({tag, "_csPot"}, csPot, 3'b111);
    chk({tag, "_sclk"}, sclkDac, 0);
    chk({tag, "_sdi"}, sdiDac, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
`ifdef WAC_SPI_FRAME_CNT_EN
    chk({tag, "_frameCnt"}, frameCnt, 0);
`endif
  endtask

  // Abort a DAC frame at its 5th rising sclk edge; no expectation is queued.
  task automatic reset_test();
    int   rises;
    int   cyc;
    logic prev;
    reqData[15:0] = 16'($urandom);
    req = 4'b0001;
    rises = 0; cyc = 0; prev = 1'b0;
    while (rises < 5 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
      if (sclkDac && !prev) rises++;
      prev = sclkDac;
    end
    chk("rst_wait", rises, 5);
    rst = 1'b1;
    req = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0;
    rr_m = 0;
    check_reset_values("abort");
    repeat (GAP_CYC + 2) begin
      @(posedge clk); #1;
      chk("abort_no_done", done, 0);
    end
  endtask

  initial begin : stimulus
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_values("reset");

    serve(4'b0001, 1'b0, 1'b1, 16'hA5C3);  // DAC word from the bring-up check
    serve(4'b0100, 1'b0, 1'b1, 16'h125A);  // pot 2, low byte 0x5A
    serve(4'b0001, 1'b1, 1'b0, 16'h0000);  // data changed and req dropped mid-frame
    serve(4'b1000, 1'b0, 1'b0, 16'h0000);  // leaves the pointer at 0
    serve_held(4'b1011, 4);                // expected order 0,1,3,0
    serve(4'b0010, 1'b0, 1'b0, 16'h0000);  // pointer moves away from 0
    reset_test();
    serve(4'b1111, 1'b0, 1'b0, 16'h0000);  // pointer must restart at 0

    for (int b = 0; b < 12; b++) begin
      serve(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), 1'b0, 16'h0000);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
